tone_envelope_gen: RTL and testbench

Upstream driver for the speaker PWM stage: produces the 8-bit `sel` level consumed by `pwm_speaker`. Generates a square-wave tone at a run-time-programmable pitch, set by the half-period in clock cycles, with a linear attack/release amplitude envelope to avoid clicks. It gives the pitch-training system run-time control of tone frequency, which the PWM stage alone cannot provide. Controlled by single-cycle `start`/`stop` pulses from the note sequencer.

---
 rtl/tone_pkg.sv | 13 +
 rtl/tone_phase_ctr.sv | 35 +++
 rtl/tone_envelope_gen.sv | 120 ++++++++++++
 tb/tb_tone_envelope_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared encodings for the tone envelope generator, its note sequencer and bench.
package tone_pkg;
  localparam int LVL_W = 8;

  typedef logic [LVL_W-1:0] level_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } tone_state_t;
endpackage

// File: rtl/tone_phase_ctr.sv
// Square-wave phase generator: holds a clamped half-period and toggles phase
// every HP cycles while enabled; parks high with the counter cleared otherwise.
module tone_phase_ctr #(
  parameter int PER_W = 20
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic             en,
  input  logic [PER_W-1:0] half_period,
  output logic             phase
);
  logic [PER_W-1:0] hp_q, cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hp_q  <= PER_W'(2);
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (load) begin
      // 0 and 1 would give a degenerate tone; run them at the fastest legal pitch
      hp_q  <= (half_period < PER_W'(2)) ? PER_W'(2) : half_period;
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (!en) begin
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (cnt_q == hp_q - PER_W'(1)) begin
      cnt_q <= '0;
      phase <= ~phase;
    end else begin
      cnt_q <= cnt_q + PER_W'(1);
    end
  end
endmodule

// File: rtl/tone_envelope_gen.sv
// Tone generator feeding pwm_speaker.sel: square wave at a programmable pitch
// with a linear attack/release envelope. Define TONE_RELEASE_EN to build the
// release ramp; without it, stop cuts the note to silence on the next edge.
module tone_envelope_gen
  import tone_pkg::*;
#(
  parameter int STEP_CYCLES = 2000,
  parameter int PER_W       = 20
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic [PER_W-1:0] half_period,
  input  logic [LVL_W-1:0] peak,
  output logic [LVL_W-1:0] sel,
  output logic             busy,
  output logic             done
);
  localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 1);

  tone_state_t      state_q, state_d;
  level_t           level_q, level_d, peak_q, peak_d;
  logic [TMR_W-1:0] tmr_q;
  logic             tick, restart, done_d, kill, phase;

  assign tick = (tmr_q == TMR_LAST);
  assign busy = (state_q != ST_IDLE);

  tone_phase_ctr #(.PER_W(PER_W)) u_phase (
    .clock       (clock),
    .resetn      (resetn),
    .load        (restart),
    .en          (busy),
    .half_period (half_period),
    .phase       (phase)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    peak_d  = peak_q;
    restart = 1'b0;
    done_d  = 1'b0;
    kill    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ATTACK;
          peak_d  = peak;
          restart = 1'b1;
        end
      end
      ST_ATTACK, ST_SUSTAIN: begin
        if (stop) begin
`ifdef TONE_RELEASE_EN
          state_d = ST_RELEASE;
`else
          state_d = ST_IDLE;
          level_d = '0;
          done_d  = 1'b1;
          kill    = 1'b1;
`endif
        end else if (start) begin
          // retrigger keeps the current level so the new note glides, no click
          state_d = ST_ATTACK;
          peak_d  = peak;
          restart = 1'b1;
        end else if (state_q == ST_ATTACK) begin
          if (level_q == peak_q)
            state_d = ST_SUSTAIN;
          else if (tick)
            level_d = (level_q < peak_q) ? level_q + LVL_W'(1) : level_q - LVL_W'(1);
        end
      end
`ifdef TONE_RELEASE_EN
      ST_RELEASE: begin
        if (start && !stop) begin
          state_d = ST_ATTACK;
          peak_d  = peak;
          restart = 1'b1;
        end else if (level_q == '0 || (tick && level_q == LVL_W'(1))) begin
          state_d = ST_IDLE;
          level_d = '0;
          done_d  = 1'b1;
        end else if (tick) begin
          level_d = level_q - LVL_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        level_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      peak_q  <= '0;
      tmr_q   <= '0;
      sel     <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      peak_q  <= peak_d;
      done    <= done_d;
      if (restart || !busy)
        tmr_q <= '0;
      else
        tmr_q <= tick ? '0 : tmr_q + TMR_W'(1);
      // a hard stop silences the output on the same edge it leaves the note
      sel <= (phase && !kill) ? level_q : '0;
    end
  end
endmodule

// File: tb/tb_tone_envelope_gen.sv
// Directed bench for tone_envelope_gen with STEP_CYCLES=4: table of
// {inputs, cycles, expected outputs} rows plus a mid-note reset sequence.
module tb_tone_envelope_gen;
  import tone_pkg::*;

  localparam int STEP = 4;
  localparam int PW   = 20;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [PW-1:0]    half_period = '0;
  logic [LVL_W-1:0] peak = '0;
  logic [LVL_W-1:0] sel;
  logic             busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic st;
    logic sp;
    int   hp;
    int   pk;
    int   cyc;
    int   e_sel;
    logic e_busy;
    logic e_done;
  } vec_t;

  vec_t vq[$];

  tone_envelope_gen #(.STEP_CYCLES(STEP), .PER_W(PW)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .stop        (stop),
    .half_period (half_period),
    .peak        (peak),
    .sel         (sel),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  function automatic void add(logic st, logic sp, int hp, int pk, int cyc,
                              int e_sel, logic e_busy, logic e_done);
    vec_t v;
    v.st = st; v.sp = sp; v.hp = hp; v.pk = pk; v.cyc = cyc;
    v.e_sel = e_sel; v.e_busy = e_busy; v.e_done = e_done;
    vq.push_back(v);
  endfunction

  function automatic void nop(int cyc, int e_sel, logic e_busy, logic e_done);
    add(1'b0, 1'b0, 0, 0, cyc, e_sel, e_busy, e_done);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // inputs are held for the first cycle only, outputs sampled after the last
  task automatic run_vec(vec_t v, int idx);
    start       = v.st;
    stop        = v.sp;
    half_period = PW'(v.hp);
    peak        = LVL_W'(v.pk);
    step();
    start = 1'b0;
    stop  = 1'b0;
    repeat (v.cyc - 1) step();
    chk($sformatf("row%0d.sel", idx), int'(sel), v.e_sel);
    chk($sformatf("row%0d.busy", idx), int'(busy), int'(v.e_busy));
    chk($sformatf("row%0d.done", idx), int'(done), int'(v.e_done));
  endtask

  initial begin
    int quiet_bad;

    // HP=5 peak=3: ramp 0->3 every 4 cycles, 5 high / 5 low
    add(1'b0, 1'b1, 5, 3, 1, 0, 1'b0, 1'b0);   // stop in IDLE ignored
    add(1'b1, 1'b0, 5, 3, 1, 0, 1'b1, 1'b0);
    nop(5, 1, 1'b1, 1'b0);
    nop(1, 0, 1'b1, 1'b0);
    nop(5, 2, 1'b1, 1'b0);
    nop(2, 3, 1'b1, 1'b0);
    nop(3, 0, 1'b1, 1'b0);
    nop(5, 3, 1'b1, 1'b0);
    nop(2, 3, 1'b1, 1'b0);
`ifdef TONE_RELEASE_EN
    add(1'b0, 1'b1, 0, 0, 1, 3, 1'b1, 1'b0);
    nop(4, 0, 1'b1, 1'b0);
    nop(3, 2, 1'b1, 1'b0);
    nop(2, 1, 1'b1, 1'b0);
    nop(2, 1, 1'b1, 1'b0);
    nop(1, 0, 1'b0, 1'b1);
    nop(1, 0, 1'b0, 1'b0);
`else
    add(1'b0, 1'b1, 0, 0, 1, 0, 1'b0, 1'b1);
    nop(1, 0, 1'b0, 1'b0);
`endif

    // start+stop together: IDLE takes start, SUSTAIN takes stop
    add(1'b1, 1'b1, 2, 1, 1, 0, 1'b1, 1'b0);
    nop(5, 1, 1'b1, 1'b0);
    nop(1, 1, 1'b1, 1'b0);
    nop(1, 0, 1'b1, 1'b0);
`ifdef TONE_RELEASE_EN
    add(1'b1, 1'b1, 7, 5, 1, 0, 1'b1, 1'b0);
    nop(1, 1, 1'b1, 1'b0);
    nop(2, 0, 1'b1, 1'b0);
    nop(1, 0, 1'b0, 1'b1);
    nop(1, 0, 1'b0, 1'b0);
`else
    add(1'b1, 1'b1, 7, 5, 1, 0, 1'b0, 1'b1);
    nop(1, 0, 1'b0, 1'b0);
`endif

    // retrigger at level 3 to peak 1 with HP 8: glide down, no drop to 0
    add(1'b1, 1'b0, 5, 3, 1, 0, 1'b1, 1'b0);
    nop(13, 3, 1'b1, 1'b0);
    nop(2, 3, 1'b1, 1'b0);
    add(1'b1, 1'b0, 8, 1, 1, 0, 1'b1, 1'b0);
    nop(1, 3, 1'b1, 1'b0);
    nop(4, 2, 1'b1, 1'b0);
    nop(3, 2, 1'b1, 1'b0);
    nop(1, 0, 1'b1, 1'b0);
    nop(8, 1, 1'b1, 1'b0);
    nop(2, 1, 1'b1, 1'b0);
`ifdef TONE_RELEASE_EN
    add(1'b0, 1'b1, 0, 0, 1, 1, 1'b1, 1'b0);
    nop(4, 1, 1'b0, 1'b1);
    nop(1, 0, 1'b0, 1'b0);
`else
    add(1'b0, 1'b1, 0, 0, 1, 0, 1'b0, 1'b1);
    nop(1, 0, 1'b0, 1'b0);
`endif

    // half_period 0 clamps to 2
    add(1'b1, 1'b0, 0, 1, 1, 0, 1'b1, 1'b0);
    nop(5, 1, 1'b1, 1'b0);
    nop(1, 1, 1'b1, 1'b0);
    nop(1, 0, 1'b1, 1'b0);
    nop(1, 0, 1'b1, 1'b0);
    nop(1, 1, 1'b1, 1'b0);
    nop(2, 0, 1'b1, 1'b0);
`ifdef TONE_RELEASE_EN
    add(1'b0, 1'b1, 0, 0, 1, 0, 1'b1, 1'b0);
    nop(4, 0, 1'b0, 1'b1);
    nop(1, 0, 1'b0, 1'b0);
`else
    add(1'b0, 1'b1, 0, 0, 1, 0, 1'b0, 1'b1);
    nop(1, 0, 1'b0, 1'b0);
`endif

    // peak 0: silent sustain, stop exits on the next cycle
    add(1'b1, 1'b0, 0, 0, 1, 0, 1'b1, 1'b0);
    nop(3, 0, 1'b1, 1'b0);
`ifdef TONE_RELEASE_EN
    add(1'b0, 1'b1, 0, 0, 1, 0, 1'b1, 1'b0);
    nop(1, 0, 1'b0, 1'b1);
    nop(1, 0, 1'b0, 1'b0);
`else
    add(1'b0, 1'b1, 0, 0, 1, 0, 1'b0, 1'b1);
    nop(1, 0, 1'b0, 1'b0);
`endif

    repeat (2) step();
    chk("rst.sel", int'(sel), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    resetn = 1'b1;
    repeat (2) step();

    foreach (vq[i]) run_vec(vq[i], i);

    // reset mid-attack clears outputs without a clock edge and leaves no done
    start = 1'b1; half_period = PW'(5); peak = 8'd3;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("pre_rst.sel", int'(sel), 1);
    chk("pre_rst.busy", int'(busy), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst.sel", int'(sel), 0);
    chk("async_rst.busy", int'(busy), 0);
    chk("async_rst.done", int'(done), 0);
    step();
    resetn = 1'b1;
    quiet_bad = 0;
    repeat (30) begin
      step();
      if (done || busy || sel != '0) quiet_bad++;
    end
    chk("post_rst.quiet", quiet_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
